// File: rtl/writeback_arbiter_pkg.sv
// Shared types and default widths for the writeback arbiter and its FU result buffers.
package writeback_arbiter_pkg;

    localparam int WB_FU_COUNT     = 4;
    localparam int WB_INST_ID_BITS = 6;
    localparam int WB_PRN_BITS     = 6;
    localparam int WB_MAX_OPERANDS = 3;
    localparam int WB_FIFO_DEPTH   = 2;
    localparam int WB_DATA_BITS    = 64;

    typedef struct packed {
        logic [WB_INST_ID_BITS-1:0]                    inst_id;
        logic [WB_MAX_OPERANDS-1:0][WB_PRN_BITS-1:0]   prn;
        logic [WB_MAX_OPERANDS-1:0][WB_DATA_BITS-1:0]  data;
        logic [WB_MAX_OPERANDS-1:0]                    data_valid;
    } wb_entry_t;

    // Bits one destination slot occupies in a flattened buffer entry: prn, data, valid.
    function automatic int wb_slot_bits(input int prn_bits);
        return prn_bits + WB_DATA_BITS + 1;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Single-clock circular buffer holding one FU's completed results until writeback.
module wb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign push_ok = push_i && (count_q != CNT_W'(DEPTH));
    assign pop_ok  = pop_i && (count_q != '0);

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/writeback_arbiter.sv
// Buffers each FU's results and retires one per cycle, round-robin, to the PRF,
// issue-queue wakeup bus and ROB.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int FU_COUNT     = WB_FU_COUNT,
    parameter int INST_ID_BITS = WB_INST_ID_BITS,
    parameter int PRN_BITS     = WB_PRN_BITS,
    parameter int MAX_OPERANDS = WB_MAX_OPERANDS,
    parameter int FIFO_DEPTH   = WB_FIFO_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fu_out_valid      [FU_COUNT],
    input  logic [INST_ID_BITS-1:0] fu_out_inst_id    [FU_COUNT],
    input  logic [PRN_BITS-1:0]     fu_out_prn        [FU_COUNT][MAX_OPERANDS],
    input  logic [WB_DATA_BITS-1:0] fu_out_data       [FU_COUNT][MAX_OPERANDS],
    input  logic                    fu_out_data_valid [FU_COUNT][MAX_OPERANDS],
    output logic                    fu_wb_ready       [FU_COUNT],
    input  logic                    rob_ready,
    output logic                    prf_write_enable  [MAX_OPERANDS],
    output logic [PRN_BITS-1:0]     prf_write_prn     [MAX_OPERANDS],
    output logic [WB_DATA_BITS-1:0] prf_write_data    [MAX_OPERANDS],
    output logic                    set_prn_ready     [MAX_OPERANDS],
    output logic [PRN_BITS-1:0]     set_prn           [MAX_OPERANDS],
    output logic                    rob_complete_valid,
    output logic [INST_ID_BITS-1:0] rob_complete_inst_id
);

    localparam int SLOT_W  = wb_slot_bits(PRN_BITS);
    localparam int ENTRY_W = INST_ID_BITS + MAX_OPERANDS * SLOT_W;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int RR_W    = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1;

    logic [ENTRY_W-1:0] fifo_dout     [FU_COUNT];
    logic [CNT_W-1:0]   fifo_count    [FU_COUNT];
    logic               fifo_push     [FU_COUNT];
    logic               fifo_pop      [FU_COUNT];
    logic               fifo_nonempty [FU_COUNT];

    logic [RR_W-1:0]    rr_q, rr_d;
    logic [RR_W:0]      idx;
    logic [RR_W-1:0]    grant_idx;
    logic               grant_any;
    logic               grant_vld;
    logic [ENTRY_W-1:0] head_entry;

    for (genvar i = 0; i < FU_COUNT; i++) begin : g_fu
        logic [ENTRY_W-1:0] din;

        // Entry layout: inst_id in the low bits, then per slot {valid, data, prn}.
        always_comb begin
            din = '0;
            din[INST_ID_BITS-1:0] = fu_out_inst_id[i];
            for (int k = 0; k < MAX_OPERANDS; k++) begin
                din[INST_ID_BITS + k*SLOT_W +: PRN_BITS]                  = fu_out_prn[i][k];
                din[INST_ID_BITS + k*SLOT_W + PRN_BITS +: WB_DATA_BITS]   = fu_out_data[i][k];
                din[INST_ID_BITS + k*SLOT_W + PRN_BITS + WB_DATA_BITS]    = fu_out_data_valid[i][k];
            end
        end

        assign fu_wb_ready[i]   = (fifo_count[i] < CNT_W'(FIFO_DEPTH));
        assign fifo_push[i]     = fu_out_valid[i] && fu_wb_ready[i];
        assign fifo_nonempty[i] = (fifo_count[i] != '0);
        assign fifo_pop[i]      = grant_vld && (grant_idx == RR_W'(i));

        wb_fifo #(
            .WIDTH (ENTRY_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (fifo_push[i]),
            .din_i   (din),
            .pop_i   (fifo_pop[i]),
            .dout_o  (fifo_dout[i]),
            .count_o (fifo_count[i])
        );
    end

    // First non-empty buffer at or after the round-robin pointer wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int off = 0; off < FU_COUNT; off++) begin
            idx = {1'b0, rr_q} + (RR_W+1)'(off);
            if (idx >= (RR_W+1)'(FU_COUNT)) begin
                idx = idx - (RR_W+1)'(FU_COUNT);
            end
            if (!grant_any && fifo_nonempty[idx[RR_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = idx[RR_W-1:0];
            end
        end
    end

    assign grant_vld = grant_any && rob_ready && !rst;

    always_comb begin
        rr_d = rr_q;
        if (grant_vld) begin
            rr_d = (grant_idx == RR_W'(FU_COUNT - 1)) ? '0 : grant_idx + RR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

    // A zeroed head keeps every output quiet when nothing is granted.
    always_comb begin
        head_entry           = grant_vld ? fifo_dout[grant_idx] : '0;
        rob_complete_valid   = grant_vld;
        rob_complete_inst_id = head_entry[INST_ID_BITS-1:0];
        for (int k = 0; k < MAX_OPERANDS; k++) begin
            prf_write_prn[k]    = head_entry[INST_ID_BITS + k*SLOT_W +: PRN_BITS];
            prf_write_data[k]   = head_entry[INST_ID_BITS + k*SLOT_W + PRN_BITS +: WB_DATA_BITS];
            prf_write_enable[k] = head_entry[INST_ID_BITS + k*SLOT_W + PRN_BITS + WB_DATA_BITS];
            set_prn_ready[k]    = prf_write_enable[k];
            set_prn[k]          = prf_write_prn[k];
        end
    end

endmodule
